bf16_addsub_arbiter: RTL and testbench

- Round-robin controller that shares one registered BF16 add/sub unit among NREQ requesters.
- Accepts operand pairs over a valid/ready handshake and issues at most one operation per cycle to the unit through registered operand ports.
- Tracks in-flight operations with a fixed-latency token pipe and routes each result back to the requester that issued it.
- Sits between the MAC lane front-ends and the single shared adder.

---
 rtl/bf16_pkg.sv | 11 +
 rtl/bf16_addsub_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/bf16_addsub_arbiter.sv | 127 ++++++++++++
 tb/tb_bf16_addsub_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared BF16 types and constants for the add/sub arbiter slice.
package bf16_pkg;

   typedef logic [15:0] bf16_t;

   localparam bf16_t BF16_ZERO  = 16'h0000;
   localparam bf16_t BF16_ONE   = 16'h3F80;
   localparam bf16_t BF16_TWO   = 16'h4000;
   localparam bf16_t BF16_THREE = 16'h4040;

endpackage

// File: rtl/bf16_addsub_arbiter_if.sv
// Requester, response and add/sub-unit signals of the shared BF16 adder arbiter.
interface bf16_addsub_arbiter_if
   import bf16_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) ();

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*16-1:0] req_a;
   logic [NREQ*16-1:0] req_b;
   logic [NREQ-1:0]    req_sub;
   bf16_t              add_a;
   bf16_t              add_b;
   logic               add_cntl;
   bf16_t              add_c;
   logic [NREQ-1:0]    rsp_valid;
   bf16_t              rsp_data;
   logic [IDW-1:0]     rsp_id;

   modport slave (
      input  req_valid, req_a, req_b, req_sub, add_c,
      output req_ready, add_a, add_b, add_cntl, rsp_valid, rsp_data, rsp_id
   );

   modport master (
      output req_valid, req_a, req_b, req_sub, add_c,
      input  req_ready, add_a, add_b, add_cntl, rsp_valid, rsp_data, rsp_id
   );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: scans req_i upward from the pointer, pointer moves past each accepted winner.
module rr_arbiter
   import bf16_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   input  logic            adv_i,
   output logic [NREQ-1:0] win_o,
   output logic [IDW-1:0]  win_idx_o
);

   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) begin
         s = s - NREQ;
      end else begin
         s = s;
      end
      return IDW'(s);
   endfunction

   // Walk from farthest to nearest so the requester closest to the pointer is left standing.
   always_comb begin
      win_idx_o = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         win_idx_o = req_i[wrap_add(ptr_q, k)] ? wrap_add(ptr_q, k) : win_idx_o;
      end
      win_o            = '0;
      win_o[win_idx_o] = |req_i;
      ptr_d            = (win_idx_o == IDW'(NREQ - 1)) ? '0 : win_idx_o + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (adv_i) begin
         ptr_q <= ptr_d;
      end else begin
         ptr_q <= ptr_q;
      end
   end

endmodule

// File: rtl/bf16_addsub_arbiter.sv
// Shares one registered BF16 add/sub unit among NREQ requesters; results are routed back by a
// fixed-latency token pipe that mirrors the unit's pipeline.
module bf16_addsub_arbiter
   import bf16_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ADD_LAT = 1,
   parameter int IDW     = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hold,
   bf16_addsub_arbiter_if.slave  bus,
   output logic                  busy,
   output logic [15:0]           op_count
);

   localparam int DEPTH = ADD_LAT + 1;

   logic [NREQ-1:0] win_s;
   logic [IDW-1:0]  grant_idx_s;
   logic [NREQ-1:0] ready_s;
   logic            fire_s;
   bf16_t           sel_a_s;
   bf16_t           sel_b_s;
   logic            sel_sub_s;

   bf16_t           add_a_q,    add_a_d;
   bf16_t           add_b_q,    add_b_d;
   logic            add_cntl_q, add_cntl_d;
   logic [DEPTH-1:0] tok_v_q,   tok_v_d;
   logic [IDW-1:0]  tok_id_q [DEPTH];
   logic [IDW-1:0]  tok_id_d [DEPTH];
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
   logic [15:0]     op_count_q,  op_count_d;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (bus.req_valid),
      .adv_i     (fire_s),
      .win_o     (win_s),
      .win_idx_o (grant_idx_s)
   );

   // Ready is withheld during reset and hold so no token can slip into a discarded pipe.
   assign ready_s = win_s & {NREQ{~hold & rst_n}};
   assign fire_s  = |(bus.req_valid & ready_s);

   always_comb begin
      sel_a_s   = BF16_ZERO;
      sel_b_s   = BF16_ZERO;
      sel_sub_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         sel_a_s   = win_s[i] ? bus.req_a[i*16 +: 16] : sel_a_s;
         sel_b_s   = win_s[i] ? bus.req_b[i*16 +: 16] : sel_b_s;
         sel_sub_s = win_s[i] ? bus.req_sub[i]        : sel_sub_s;
      end

      if (fire_s) begin
         add_a_d    = sel_a_s;
         add_b_d    = sel_b_s;
         add_cntl_d = sel_sub_s;
      end else begin
         add_a_d    = add_a_q;
         add_b_d    = add_b_q;
         add_cntl_d = add_cntl_q;
      end

      tok_v_d     = {tok_v_q[DEPTH-2:0], fire_s};
      tok_id_d[0] = grant_idx_s;
      for (int s = 1; s < DEPTH; s++) begin
         tok_id_d[s] = tok_id_q[s-1];
      end

      rsp_valid_d                      = '0;
      rsp_valid_d[tok_id_q[DEPTH-1]]   = tok_v_q[DEPTH-1];
      if (tok_v_q[DEPTH-1]) begin
         rsp_id_d = tok_id_q[DEPTH-1];
      end else begin
         rsp_id_d = rsp_id_q;
      end

      op_count_d = op_count_q + {15'd0, fire_s};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         add_a_q     <= BF16_ZERO;
         add_b_q     <= BF16_ZERO;
         add_cntl_q  <= 1'b0;
         tok_v_q     <= '0;
         for (int s = 0; s < DEPTH; s++) begin
            tok_id_q[s] <= '0;
         end
         rsp_valid_q <= '0;
         rsp_id_q    <= '0;
         op_count_q  <= 16'd0;
      end else begin
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_cntl_q  <= add_cntl_d;
         tok_v_q     <= tok_v_d;
         for (int s = 0; s < DEPTH; s++) begin
            tok_id_q[s] <= tok_id_d[s];
         end
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         op_count_q  <= op_count_d;
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.add_cntl  = add_cntl_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = bus.add_c;
   assign busy          = |tok_v_q;
   assign op_count      = op_count_q;

endmodule

// File: tb/tb_bf16_addsub_arbiter.sv
// Directed bench for bf16_addsub_arbiter: a per-cycle reference model of grants, responses and
// counters, plus literal expectations for the key scenarios.
module tb_bf16_addsub_arbiter;

   localparam int NREQ    = 4;
   localparam int ADD_LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hold;
   logic        busy;
   logic [15:0] op_count;

   bf16_addsub_arbiter_if #(.NREQ(NREQ)) bus ();

   bf16_addsub_arbiter #(.NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (hold),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Small exact BF16 integers are all this bench needs.
   function automatic int bf_val(input logic [15:0] x);
      case (x)
         16'h0000: return 0;
         16'h3F80: return 1;
         16'h4000: return 2;
         16'h4040: return 3;
         16'h4080: return 4;
         16'h40A0: return 5;
         16'h40C0: return 6;
         default:  return -100;
      endcase
   endfunction

   function automatic logic [15:0] bf_enc(input int v);
      case (v)
         0:       return 16'h0000;
         1:       return 16'h3F80;
         2:       return 16'h4000;
         3:       return 16'h4040;
         4:       return 16'h4080;
         5:       return 16'h40A0;
         6:       return 16'h40C0;
         default: return 16'hFFFF;
      endcase
   endfunction

   function automatic logic [15:0] bf_ref(input logic [15:0] a, input logic [15:0] b, input logic sub);
      return bf_enc(sub ? bf_val(a) - bf_val(b) : bf_val(a) + bf_val(b));
   endfunction

   // Shared add/sub unit: input register then result register.
   logic [15:0] u_a, u_b;
   logic        u_sub;
   always @(posedge clk) begin
      u_a       <= bus.add_a;
      u_b       <= bus.add_b;
      u_sub     <= bus.add_cntl;
      bus.add_c <= bf_ref(u_a, u_b, u_sub);
   end

   typedef struct {
      int          e;
      int          id;
      logic [15:0] res;
   } op_t;

   op_t         infl[$];
   int          m_edge = 0;
   int          m_ptr = 0;
   int          m_last_id = 0;
   logic [15:0] m_cnt = 16'd0;
   logic [15:0] m_a = 16'd0, m_b = 16'd0;
   logic        m_sub = 1'b0;
   bit          known = 1'b0;
   int          rsp_log_id[$];
   logic [15:0] rsp_log_data[$];

   // Reference model: state reflects the edge just passed; inputs seen here are those of the next edge.
   always @(negedge clk) begin : model
      int              w;
      logic [NREQ-1:0] exp_ready;
      logic [NREQ-1:0] exp_rv;
      logic [15:0]     exp_data;
      op_t             op;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
         if (w < 0 && bus.req_valid[(m_ptr + k) % NREQ] == 1'b1) w = (m_ptr + k) % NREQ;
      end
      exp_ready = '0;
      if (w >= 0 && hold == 1'b0 && rst_n == 1'b1) exp_ready[w] = 1'b1;
      exp_rv   = '0;
      exp_data = 16'd0;
      if (infl.size() > 0 && infl[0].e == m_edge - (ADD_LAT + 1)) begin
         exp_rv[infl[0].id] = 1'b1;
         exp_data  = infl[0].res;
         m_last_id = infl[0].id;
         void'(infl.pop_front());
      end
      if (bus.rsp_valid != '0) begin
         rsp_log_id.push_back(int'(bus.rsp_id));
         rsp_log_data.push_back(bus.rsp_data);
      end
      if (known) begin
         chk("m_req_ready", 32'(bus.req_ready), 32'(exp_ready));
         chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
         chk("m_rsp_id", 32'(bus.rsp_id), 32'(m_last_id));
         if (exp_rv != '0) chk("m_rsp_data", 32'(bus.rsp_data), 32'(exp_data));
         chk("m_busy", 32'(busy), 32'(infl.size() > 0));
         chk("m_op_count", 32'(op_count), 32'(m_cnt));
         chk("m_add_a", 32'(bus.add_a), 32'(m_a));
         chk("m_add_b", 32'(bus.add_b), 32'(m_b));
         chk("m_add_cntl", 32'(bus.add_cntl), 32'(m_sub));
      end
      m_edge++;
      if (rst_n == 1'b0) begin
         infl.delete();
         m_ptr = 0; m_cnt = 16'd0; m_a = 16'd0; m_b = 16'd0; m_sub = 1'b0; m_last_id = 0;
         known = 1'b1;
      end else if (exp_ready != '0) begin
         op.e   = m_edge;
         op.id  = w;
         op.res = bf_ref(bus.req_a[w*16 +: 16], bus.req_b[w*16 +: 16], bus.req_sub[w]);
         infl.push_back(op);
         m_ptr = (w + 1) % NREQ;
         m_cnt = m_cnt + 16'd1;
         m_a   = bus.req_a[w*16 +: 16];
         m_b   = bus.req_b[w*16 +: 16];
         m_sub = bus.req_sub[w];
      end
   end

   int          pend[NREQ];
   int          nxt[NREQ];
   logic [15:0] opa[NREQ][4];
   logic [15:0] opb[NREQ][4];
   logic        ops[NREQ][4];
   int          grant_log[$];

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic sub);
      bus.req_a[i*16 +: 16] = a;
      bus.req_b[i*16 +: 16] = b;
      bus.req_sub[i]        = sub;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Each requester offers its queued operations, advancing only after a handshake.
   task automatic drive(input int budget);
      logic [NREQ-1:0] fired;
      bit              done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = (pend[i] > 0);
            set_op(i, opa[i][nxt[i] % 4], opb[i][nxt[i] % 4], ops[i][nxt[i] % 4]);
         end
         @(negedge clk);
         fired = bus.req_valid & bus.req_ready;
         step();
         done = 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (fired[i]) begin
               grant_log.push_back(i);
               pend[i]--;
               nxt[i]++;
            end
            if (pend[i] > 0) done = 1'b0;
         end
      end
      bus.req_valid = '0;
      chk("drive_done", 32'(done), 32'd1);
   endtask

   task automatic clear_ops();
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 0;
         nxt[i]  = 0;
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      hold          = 1'b0;
      bus.req_valid = '1;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_sub   = '0;
      clear_ops();

      // Reset with all requesters valid.
      repeat (2) step();
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_add_a", 32'(bus.add_a), 32'd0);
      rst_n         = 1'b1;
      bus.req_valid = '0;

      // Single op from requester 2: 1 + 2.
      set_op(2, 16'h3F80, 16'h4000, 1'b0);
      bus.req_valid[2] = 1'b1;
      @(negedge clk);
      chk("single_ready", 32'(bus.req_ready), 32'h4);
      step();
      bus.req_valid = '0;
      chk("single_add_a", 32'(bus.add_a), 32'h3F80);
      chk("single_add_b", 32'(bus.add_b), 32'h4000);
      chk("single_add_cntl", 32'(bus.add_cntl), 32'd0);
      step();
      chk("single_rsp_early", 32'(bus.rsp_valid), 32'd0);
      step();
      chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      chk("single_rsp_id", 32'(bus.rsp_id), 32'd2);
      chk("single_rsp_data", 32'(bus.rsp_data), 32'h4040);
      chk("single_op_count", 32'(op_count), 32'd1);
      step();
      chk("single_rsp_once", 32'(bus.rsp_valid), 32'd0);

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;

      // Round robin: every requester has two ops queued.
      clear_ops();
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 2;
         for (int k = 0; k < 4; k++) begin
            opa[i][k] = bf_enc(1 + (k % 2));
            opb[i][k] = bf_enc(1 + (i % 3));
            ops[i][k] = 1'b0;
         end
      end
      grant_log.delete();
      rsp_log_id.delete();
      drive(20);
      repeat (4) step();
      chk("rr_grants", 32'(grant_log.size()), 32'd8);
      for (int k = 0; k < 8; k++) chk("rr_order", 32'(grant_log[k]), 32'(k % 4));
      chk("rr_rsp_count", 32'(rsp_log_id.size()), 32'd8);
      chk("rr_op_count", 32'(op_count), 32'd8);

      // Subtract and routing: r1 does 3 - 1, r3 does 2 + 2.
      clear_ops();
      opa[1][0] = 16'h4040; opb[1][0] = 16'h3F80; ops[1][0] = 1'b1; pend[1] = 1;
      opa[3][0] = 16'h4000; opb[3][0] = 16'h4000; ops[3][0] = 1'b0; pend[3] = 1;
      rsp_log_id.delete();
      rsp_log_data.delete();
      drive(10);
      repeat (4) step();
      chk("sub_rsp_count", 32'(rsp_log_id.size()), 32'd2);
      chk("sub_first_id", 32'(rsp_log_id[0]), 32'd1);
      chk("sub_first_data", 32'(rsp_log_data[0]), 32'h4000);
      chk("sub_second_id", 32'(rsp_log_id[1]), 32'd3);
      chk("sub_second_data", 32'(rsp_log_data[1]), 32'h4080);

      // hold with two operations in flight and requester 0 waiting.
      rsp_log_id.delete();
      set_op(1, 16'h3F80, 16'h3F80, 1'b0);
      set_op(2, 16'h4000, 16'h3F80, 1'b0);
      bus.req_valid = 4'b0110;
      step();
      bus.req_valid[1] = 1'b0;
      step();
      bus.req_valid[2] = 1'b0;
      hold = 1'b1;
      set_op(0, 16'h3F80, 16'h4000, 1'b0);
      bus.req_valid[0] = 1'b1;
      @(negedge clk);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      repeat (3) step();
      chk("hold_drained_rsps", 32'(rsp_log_id.size()), 32'd2);
      chk("hold_busy_low", 32'(busy), 32'd0);
      hold = 1'b0;
      @(negedge clk);
      chk("hold_release_ready", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = '0;
      repeat (4) step();

      // Reset right after a handshake discards the op and rewinds the pointer.
      rsp_log_id.delete();
      set_op(2, 16'h3F80, 16'h3F80, 1'b0);
      bus.req_valid[2] = 1'b1;
      step();
      bus.req_valid = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("midrst_no_rsp", 32'(rsp_log_id.size()), 32'd0);
      bus.req_valid = '1;
      @(negedge clk);
      chk("midrst_ptr", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = '0;
      repeat (4) step();

      // op_count wrap.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      clear_ops();
      for (int k = 0; k < 4; k++) begin
         opa[0][k] = 16'h3F80; opb[0][k] = 16'h3F80; ops[0][k] = 1'b0;
      end
      pend[0] = 65535;
      drive(70000);
      chk("wrap_ffff", 32'(op_count), 32'hFFFF);
      pend[0] = 1;
      drive(10);
      chk("wrap_zero", 32'(op_count), 32'h0000);
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
